// File: rtl/alu_result_checker.sv
// alu_result_checker: passive monitor beside the 5-bit signed ALU.
// Recomputes each result, delays it to match the ALU latency, compares it
// with out_top, keeps saturating pass/fail/skip counters and latches the
// first mismatch. With STOP_ON_ERR it parks in HALT until cleared.
module alu_result_checker #(
  parameter int LATENCY     = 1,    // ALU input-to-output delay, 1..4
  parameter int CNT_W       = 16,   // width of each event counter
  parameter bit STOP_ON_ERR = 1'b0  // halt on the first mismatch
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [4:0]       in1,
  input  logic [4:0]       in2,
  input  logic [2:0]       opcode,
  input  logic [8:0]       out_top,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] skip_cnt,
  output logic             err,
  output logic [2:0]       err_opcode,
  output logic [8:0]       err_expected,
  output logic [8:0]       err_actual,
  output logic             halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Reference arithmetic on operands sign-extended to the result width.
  logic signed [8:0] w_a9;
  logic signed [8:0] w_b9;
  logic signed [8:0] w_div_den;
  logic signed [8:0] w_prod;
  logic signed [8:0] w_quot;
  logic [4:0]        w_or5;
  logic [4:0]        w_and5;
  logic [8:0]        w_exp_in;
  logic              w_skip_in;
  logic              w_push;

  assign w_a9      = {{4{in1[4]}}, in1};
  assign w_b9      = {{4{in2[4]}}, in2};
  // Divide-by-zero samples are skipped; a dummy divisor keeps the divider defined.
  assign w_div_den = (in2 == 5'd0) ? 9'sd1 : w_b9;
  // Product is taken at 9 bits, so only its low 9 bits survive.
  assign w_prod    = w_a9 * w_b9;
  assign w_quot    = w_a9 / w_div_den;
  assign w_or5     = in1 | in2;
  assign w_and5    = in1 & in2;
  assign w_skip_in = (opcode == 3'd3) && (in2 == 5'd0);
  assign w_push    = en && (r_state != S_HALT);

  // Expected result for the sample on the inputs this cycle.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    w_exp_in = 9'd0;
    case (opcode)
      3'd0: w_exp_in = w_a9 + w_b9;
      3'd1: w_exp_in = w_a9 - w_b9;
      3'd2: w_exp_in = w_prod;
      3'd3: w_exp_in = w_quot;
      3'd4: w_exp_in = {{4{w_or5[4]}}, w_or5};
      3'd5: w_exp_in = {{4{w_and5[4]}}, w_and5};
      3'd6: w_exp_in = {{4{~w_and5[4]}}, ~w_and5};
      3'd7: w_exp_in = {{4{~w_or5[4]}}, ~w_or5};
      default: w_exp_in = 9'd0;
    endcase
  end

  // Delay pipeline: valid bits are control and get reset; payload does not.
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_skip_pipe;
  logic [8:0]         r_exp_pipe [LATENCY];
  logic [2:0]         r_op_pipe  [LATENCY];

  // Shift the valid bits every cycle; clr or reset drops all in-flight samples.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the values from before the edge, independent of statement order.
    if (rst) begin
      r_vld <= '0;
    end else if (clr) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_push;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  // Shift the payload alongside the valid bits.
  always_ff @(posedge clk) begin
    // NOTE: the payload is deliberately left out of reset; it is only looked at
    // when its valid bit is set, so resetting it would buy nothing.
    r_exp_pipe[0]  <= w_exp_in;
    r_op_pipe[0]   <= opcode;
    r_skip_pipe[0] <= w_skip_in;
    for (int i = 1; i < LATENCY; i++) begin
      r_exp_pipe[i]  <= r_exp_pipe[i-1];
      r_op_pipe[i]   <= r_op_pipe[i-1];
      r_skip_pipe[i] <= r_skip_pipe[i-1];
    end
  end

  // Compare at the pipeline tail; a clear in the same cycle discards it.
  logic       w_cmp;
  logic       w_skip_hit;
  logic       w_pass_hit;
  logic       w_fail_hit;
  logic [8:0] w_tail_exp;
  logic [2:0] w_tail_op;

  assign w_tail_exp = r_exp_pipe[LATENCY-1];
  assign w_tail_op  = r_op_pipe[LATENCY-1];
  assign w_cmp      = r_vld[LATENCY-1] && (r_state != S_HALT) && !clr;
  assign w_skip_hit = w_cmp && r_skip_pipe[LATENCY-1];
  assign w_pass_hit = w_cmp && !r_skip_pipe[LATENCY-1] && (out_top == w_tail_exp);
  assign w_fail_hit = w_cmp && !r_skip_pipe[LATENCY-1] && (out_top != w_tail_exp);

  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [CNT_W-1:0] r_skip_cnt;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_skip_cnt <= '0;
    end else if (clr) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_skip_cnt <= '0;
    end else begin
      if (w_pass_hit && (r_pass_cnt != '1)) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
      if (w_fail_hit && (r_fail_cnt != '1)) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
      if (w_skip_hit && (r_skip_cnt != '1)) r_skip_cnt <= r_skip_cnt + CNT_W'(1);
    end
  end

  logic       r_err;
  logic [2:0] r_err_opcode;
  logic [8:0] r_err_expected;
  logic [8:0] r_err_actual;

  // Latch only the first mismatch; later ones just bump fail_cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err          <= 1'b0;
      r_err_opcode   <= 3'd0;
      r_err_expected <= 9'd0;
      r_err_actual   <= 9'd0;
    end else if (clr) begin
      r_err          <= 1'b0;
      r_err_opcode   <= 3'd0;
      r_err_expected <= 9'd0;
      r_err_actual   <= 9'd0;
    end else if (w_fail_hit && !r_err) begin
      r_err          <= 1'b1;
      r_err_opcode   <= w_tail_op;
      r_err_expected <= w_tail_exp;
      r_err_actual   <= out_top;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a mismatch beats en dropping in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (en) w_state_nxt = S_RUN;
      S_RUN: begin
        if (STOP_ON_ERR && w_fail_hit) w_state_nxt = S_HALT;
        else if (!en)                  w_state_nxt = S_IDLE;
      end
      S_HALT: if (clr) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    halted = (r_state == S_HALT);
  end

  assign pass_cnt     = r_pass_cnt;
  assign fail_cnt     = r_fail_cnt;
  assign skip_cnt     = r_skip_cnt;
  assign err          = r_err;
  assign err_opcode   = r_err_opcode;
  assign err_expected = r_err_expected;
  assign err_actual   = r_err_actual;

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker. Instance u_dut (LATENCY=1) is fed by a
// scoreboard queue acting as the ALU: each driven sample pushes its reference
// result (optionally corrupted); the entry is popped and presented on out_top
// one cycle later, and a bench-side model of the counters is updated.
// Instance u_dut_h (LATENCY=3, STOP_ON_ERR=1) covers HALT, clr and reset.
module tb_alu_result_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // LATENCY=1 instance
  logic        rst, en, clr;
  logic [4:0]  in1, in2;
  logic [2:0]  opcode;
  logic [8:0]  out_top;
  logic [15:0] pass_cnt, fail_cnt, skip_cnt;
  logic        err, halted;
  logic [2:0]  err_opcode;
  logic [8:0]  err_expected, err_actual;

  // LATENCY=3, STOP_ON_ERR=1 instance
  logic        h_rst, h_en, h_clr;
  logic [4:0]  h_in1, h_in2;
  logic [2:0]  h_opcode;
  logic [8:0]  h_out_top;
  logic [15:0] h_pass_cnt, h_fail_cnt, h_skip_cnt;
  logic        h_err, h_halted;
  logic [2:0]  h_err_opcode;
  logic [8:0]  h_err_expected, h_err_actual;

  alu_result_checker #(.LATENCY(1), .CNT_W(16), .STOP_ON_ERR(1'b0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .in1(in1), .in2(in2), .opcode(opcode), .out_top(out_top),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .skip_cnt(skip_cnt),
    .err(err), .err_opcode(err_opcode), .err_expected(err_expected),
    .err_actual(err_actual), .halted(halted)
  );

  alu_result_checker #(.LATENCY(3), .CNT_W(16), .STOP_ON_ERR(1'b1)) u_dut_h (
    .clk(clk), .rst(h_rst), .en(h_en), .clr(h_clr),
    .in1(h_in1), .in2(h_in2), .opcode(h_opcode), .out_top(h_out_top),
    .pass_cnt(h_pass_cnt), .fail_cnt(h_fail_cnt), .skip_cnt(h_skip_cnt),
    .err(h_err), .err_opcode(h_err_opcode), .err_expected(h_err_expected),
    .err_actual(h_err_actual), .halted(h_halted)
  );

  typedef struct {
    logic [8:0] exp_val;
    logic [8:0] act_val;
    logic [2:0] op;
    bit         skip;
  } sb_t;

  sb_t sb_q[$];

  int total = 0;
  int bad   = 0;

  // Model of the LATENCY=1 instance's observable state
  int         m_pass, m_fail, m_skip;
  bit         m_err;
  logic [2:0] m_eop;
  logic [8:0] m_eexp, m_eact;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // Reference ALU written straight from the operation table.
  function automatic logic [8:0] ref_alu(input logic [4:0] a, input logic [4:0] b,
                                         input logic [2:0] op);
    int ai, bi, r;
    logic [4:0]  l;
    logic [31:0] rv;
    ai = $signed(a);
    bi = $signed(b);
    r  = 0;
    l  = 5'd0;
    case (op)
      3'd0: r = ai + bi;
      3'd1: r = ai - bi;
      3'd2: r = ai * bi;
      3'd3: r = (bi == 0) ? 0 : ai / bi;
      3'd4: begin l = a | b;    r = $signed(l); end
      3'd5: begin l = a & b;    r = $signed(l); end
      3'd6: begin l = ~(a & b); r = $signed(l); end
      default: begin l = ~(a | b); r = $signed(l); end
    endcase
    rv = r;
    return rv[8:0];
  endfunction

  task automatic check_all(input string tag);
    check({tag, "/pass"}, 32'(pass_cnt), 32'(m_pass));
    check({tag, "/fail"}, 32'(fail_cnt), 32'(m_fail));
    check({tag, "/skip"}, 32'(skip_cnt), 32'(m_skip));
    check({tag, "/err"}, 32'(err), 32'(m_err));
    check({tag, "/err_op"}, 32'(err_opcode), 32'(m_eop));
    check({tag, "/err_exp"}, 32'(err_expected), 32'(m_eexp));
    check({tag, "/err_act"}, 32'(err_actual), 32'(m_eact));
    check({tag, "/halted"}, 32'(halted), 32'd0);
  endtask

  // One clock of the LATENCY=1 instance: present the ALU result of the
  // previous sample, drive a new sample, advance, update the model, check.
  task automatic cyc(input string tag, input bit v, input logic [4:0] a, input logic [4:0] b,
                     input logic [2:0] op, input bit flt, input logic [8:0] fval, input bit c);
    sb_t e, n;
    bit  have;
    have = (sb_q.size() > 0);
    if (have) begin
      e = sb_q.pop_front();
      out_top = e.act_val;
    end else begin
      out_top = 9'd0;
    end
    en = v; in1 = a; in2 = b; opcode = op; clr = c;
    if (v && !c) begin
      n.exp_val = ref_alu(a, b, op);
      n.skip    = (op == 3'd3) && (b == 5'd0);
      n.act_val = flt ? fval : n.exp_val;
      n.op      = op;
      sb_q.push_back(n);
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
    if (c) begin
      m_pass = 0; m_fail = 0; m_skip = 0; m_err = 1'b0;
      m_eop = 3'd0; m_eexp = 9'd0; m_eact = 9'd0;
      sb_q.delete();
    end else if (have) begin
      if (e.skip) m_skip++;
      else if (e.act_val == e.exp_val) m_pass++;
      else begin
        m_fail++;
        if (!m_err) begin
          m_err = 1'b1; m_eop = e.op; m_eexp = e.exp_val; m_eact = e.act_val;
        end
      end
    end
    check_all(tag);
  endtask

  // One clock of the LATENCY=3 instance; h_out_top stays at 5, the correct
  // result for (2,3,add), so any other sample compared there mismatches.
  task automatic h_cyc(input bit v, input logic [4:0] a, input logic [4:0] b);
    h_en = v; h_in1 = a; h_in2 = b; h_opcode = 3'd0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; in1 = '0; in2 = '0; opcode = '0; out_top = '0;
    h_rst = 1'b1; h_en = 1'b0; h_clr = 1'b0; h_in1 = '0; h_in2 = '0; h_opcode = '0;
    h_out_top = 9'd5;
    m_pass = 0; m_fail = 0; m_skip = 0; m_err = 1'b0;
    m_eop = 3'd0; m_eexp = 9'd0; m_eact = 9'd0;

    @(posedge clk);
    #1;
    check_all("reset");
    check("reset/h_halted", 32'(h_halted), 32'd0);
    rst = 1'b0;
    h_rst = 1'b0;

    // Arithmetic: (2,3,add) (-2,6,sub) (2,5,mul) (12,4,div)
    cyc("add", 1'b1, 5'd2, 5'd3, 3'd0, 1'b0, 9'd0, 1'b0);
    cyc("sub", 1'b1, 5'h1E, 5'd6, 3'd1, 1'b0, 9'd0, 1'b0);
    cyc("mul", 1'b1, 5'd2, 5'd5, 3'd2, 1'b0, 9'd0, 1'b0);
    cyc("div", 1'b1, 5'd12, 5'd4, 3'd3, 1'b0, 9'd0, 1'b0);
    // Logic: (6,-6,or)=-2 (2,0,and)=0 (-8,5,nand)=-1 (0,0,nor)=-1
    cyc("or", 1'b1, 5'd6, 5'h1A, 3'd4, 1'b0, 9'd0, 1'b0);
    check("basic/pass4", 32'(pass_cnt), 32'd4);
    cyc("and", 1'b1, 5'd2, 5'd0, 3'd5, 1'b0, 9'd0, 1'b0);
    cyc("nand", 1'b1, 5'h18, 5'd5, 3'd6, 1'b0, 9'd0, 1'b0);
    cyc("nor", 1'b1, 5'd0, 5'd0, 3'd7, 1'b0, 9'd0, 1'b0);
    // Boundaries: (-16,-16,mul)=-256, (-16,-1,div)=16, (7,0,div) skipped
    cyc("mul_min", 1'b1, 5'h10, 5'h10, 3'd2, 1'b0, 9'd0, 1'b0);
    check("logic/pass8", 32'(pass_cnt), 32'd8);
    cyc("div_min", 1'b1, 5'h10, 5'h1F, 3'd3, 1'b0, 9'd0, 1'b0);
    cyc("div_zero", 1'b1, 5'd7, 5'd0, 3'd3, 1'b0, 9'd0, 1'b0);
    check("bound/pass10", 32'(pass_cnt), 32'd10);
    // Fault: (2,3,add) answered with 6
    cyc("fault1", 1'b1, 5'd2, 5'd3, 3'd0, 1'b1, 9'd6, 1'b0);
    check("skip/skip1", 32'(skip_cnt), 32'd1);
    check("skip/fail0", 32'(fail_cnt), 32'd0);
    // Second fault: (1,1,sub) answered with 7
    cyc("fault2", 1'b1, 5'd1, 5'd1, 3'd1, 1'b1, 9'd7, 1'b0);
    check("fault1/fail", 32'(fail_cnt), 32'd1);
    check("fault1/err", 32'(err), 32'd1);
    check("fault1/err_op", 32'(err_opcode), 32'd0);
    check("fault1/err_exp", 32'(err_expected), 32'd5);
    check("fault1/err_act", 32'(err_actual), 32'd6);
    cyc("drain", 1'b0, 5'd0, 5'd0, 3'd0, 1'b0, 9'd0, 1'b0);
    check("fault2/fail", 32'(fail_cnt), 32'd2);
    check("fault2/err_exp", 32'(err_expected), 32'd5);
    check("fault2/err_act", 32'(err_actual), 32'd6);
    // clr on the same edge as a failing compare discards that compare
    cyc("pre_clr", 1'b1, 5'd2, 5'd3, 3'd0, 1'b1, 9'd9, 1'b0);
    cyc("clr", 1'b0, 5'd0, 5'd0, 3'd0, 1'b0, 9'd0, 1'b1);
    check("clr/fail0", 32'(fail_cnt), 32'd0);
    check("clr/err0", 32'(err), 32'd0);
    cyc("post_clr", 1'b0, 5'd0, 5'd0, 3'd0, 1'b0, 9'd0, 1'b0);

    // HALT: four good samples, one bad (1,1,add)=2 vs out_top 5, more good
    for (int i = 0; i < 4; i++) h_cyc(1'b1, 5'd2, 5'd3);
    check("halt/pass1", 32'(h_pass_cnt), 32'd1);
    h_cyc(1'b1, 5'd1, 5'd1);
    h_cyc(1'b1, 5'd2, 5'd3);
    h_cyc(1'b1, 5'd2, 5'd3);
    check("halt/edge2_halted", 32'(h_halted), 32'd0);
    check("halt/edge2_pass", 32'(h_pass_cnt), 32'd4);
    h_cyc(1'b1, 5'd2, 5'd3);
    check("halt/edge3_halted", 32'(h_halted), 32'd1);
    check("halt/fail1", 32'(h_fail_cnt), 32'd1);
    check("halt/err", 32'(h_err), 32'd1);
    check("halt/err_exp", 32'(h_err_expected), 32'd2);
    check("halt/err_act", 32'(h_err_actual), 32'd5);
    h_cyc(1'b1, 5'd1, 5'd1);
    h_cyc(1'b1, 5'd1, 5'd1);
    h_cyc(1'b1, 5'd2, 5'd3);
    check("frozen/pass", 32'(h_pass_cnt), 32'd4);
    check("frozen/fail", 32'(h_fail_cnt), 32'd1);
    check("frozen/halted", 32'(h_halted), 32'd1);
    h_clr = 1'b1;
    h_cyc(1'b0, 5'd0, 5'd0);
    h_clr = 1'b0;
    check("hclr/halted", 32'(h_halted), 32'd0);
    check("hclr/pass", 32'(h_pass_cnt), 32'd0);
    check("hclr/fail", 32'(h_fail_cnt), 32'd0);
    check("hclr/err", 32'(h_err), 32'd0);
    check("hclr/err_exp", 32'(h_err_expected), 32'd0);
    for (int i = 0; i < 4; i++) h_cyc(1'b0, 5'd0, 5'd0);
    check("hclr/no_late", 32'(h_pass_cnt), 32'd0);

    // Reset mid-stream with three good samples still in flight
    for (int i = 0; i < 4; i++) h_cyc(1'b1, 5'd2, 5'd3);
    check("mid/pass1", 32'(h_pass_cnt), 32'd1);
    #2;
    h_rst = 1'b1;
    h_en  = 1'b0;
    #1;
    check("mid/async_pass", 32'(h_pass_cnt), 32'd0);
    @(posedge clk);
    #1;
    h_rst = 1'b0;
    for (int i = 0; i < 5; i++) h_cyc(1'b0, 5'd2, 5'd3);
    check("mid/late_pass", 32'(h_pass_cnt), 32'd0);
    check("mid/late_fail", 32'(h_fail_cnt), 32'd0);
    check("mid/halted", 32'(h_halted), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
